// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_write_arbiter
//  Purpose  : Shares the register-file write port between the main pipeline
//             writeback (A) and a late multi-cycle writeback source (B).
//             B results wait in a 1-entry buffer. A wait counter forces B
//             through once it has lost MAX_WAIT times to A.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [4:0]        a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [4:0]        b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic [4:0]        writeRegister,
    output logic              regWrite,
    output logic [DATA_W-1:0] writeData,
    output logic [31:0]       pending,
    output logic              b_forced
);

    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);
    localparam logic [4:0] c_zero_reg = 5'(ZERO_REG);

    // B holding buffer and its starvation counter
    logic              r_buf_valid;
    logic [4:0]        r_buf_reg;
    logic [DATA_W-1:0] r_buf_data;
    logic [3:0]        r_wait_cnt;

    // Registered write-port outputs
    logic              r_reg_write;
    logic [4:0]        r_write_register;
    logic [DATA_W-1:0] r_write_data;
    logic              r_b_forced;

    logic              w_force;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_b_hs;
    logic [31:0]       w_pending;

    // The buffered entry has lost MAX_WAIT times and must win this cycle
    assign w_force   = r_buf_valid && (r_wait_cnt == c_max_wait);
    assign w_grant_b = r_buf_valid && (w_force || !a_valid);
    assign w_grant_a = a_valid && !w_force;

    assign a_ready   = reset_n && !w_force;
    // No load while occupied, so a drain and a load never share a cycle
    assign b_ready   = reset_n && !r_buf_valid;
    assign w_b_hs    = b_valid && b_ready;

    // Hazard-unit view of the unwritten buffered destination register
    always_comb begin
        w_pending = '0;
        if (r_buf_valid && (r_buf_reg != c_zero_reg)) begin
            w_pending[r_buf_reg] = 1'b1;
        end
    end

    assign pending = w_pending;

    // Buffer occupancy and starvation counting
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_buf_valid <= 1'b0;
            r_buf_reg   <= '0;
            r_buf_data  <= '0;
            r_wait_cnt  <= '0;
        end else if (w_grant_b) begin
            r_buf_valid <= 1'b0;
            r_wait_cnt  <= '0;
        end else if (w_b_hs) begin
            r_buf_valid <= 1'b1;
            r_buf_reg   <= b_reg;
            r_buf_data  <= b_data;
            r_wait_cnt  <= '0;
        end else if (r_buf_valid && w_grant_a) begin
            r_wait_cnt  <= r_wait_cnt + 4'd1;
        end
    end

    // Register-file write stage: one cycle after the grant decision
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_reg_write      <= 1'b0;
            r_write_register <= '0;
            r_write_data     <= '0;
            r_b_forced       <= 1'b0;
        end else begin
            r_b_forced <= w_grant_b && w_force;
            if (w_grant_b) begin
                r_write_register <= r_buf_reg;
                r_write_data     <= r_buf_data;
                r_reg_write      <= (r_buf_reg != c_zero_reg);
            end else if (w_grant_a) begin
                r_write_register <= a_reg;
                r_write_data     <= a_data;
                r_reg_write      <= (a_reg != c_zero_reg);
            end else begin
                r_reg_write      <= 1'b0;
            end
        end
    end

    assign regWrite      = r_reg_write;
    assign writeRegister = r_write_register;
    assign writeData     = r_write_data;
    assign b_forced      = r_b_forced;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_write_arbiter
//  Purpose  : Randomized self-checking bench for rf_write_arbiter against a
//             queue-based reference model of the write-port sharing rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    localparam int DATA_W   = 64;
    localparam int MAX_WAIT = 4;
    localparam int ZERO_REG = 31;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              a_valid;
    logic              a_ready;
    logic [4:0]        a_reg;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [4:0]        b_reg;
    logic [DATA_W-1:0] b_data;
    logic [4:0]        writeRegister;
    logic              regWrite;
    logic [DATA_W-1:0] writeData;
    logic [31:0]       pending;
    logic              b_forced;

    rf_write_arbiter #(
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT),
        .ZERO_REG(ZERO_REG)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_reg        (a_reg),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_reg        (b_reg),
        .b_data       (b_data),
        .writeRegister(writeRegister),
        .regWrite     (regWrite),
        .writeData    (writeData),
        .pending      (pending),
        .b_forced     (b_forced)
    );

    always #5 clk = ~clk;

    int vectors   = 0;
    int miscompares = 0;

    // Reference model: B results waiting to be written, and how often the head lost
    int                q_reg[$];
    logic [DATA_W-1:0] q_data[$];
    int                losses;
    logic              m_we;
    logic [4:0]        m_reg;
    logic [DATA_W-1:0] m_data;
    logic              m_forced;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] pick_reg();
        // Hit the hardwired-zero register often enough to exercise it
        if ($urandom_range(0, 7) == 0) return 5'(ZERO_REG);
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic model_reset();
        q_reg.delete();
        q_data.delete();
        losses   = 0;
        m_we     = 1'b0;
        m_reg    = '0;
        m_data   = '0;
        m_forced = 1'b0;
    endtask

    task automatic run_cycles(input int n, input int a_pct, input int b_pct, input int rst_pct);
        logic        starving;
        logic        exp_a_ready;
        logic        exp_b_ready;
        logic [31:0] exp_pending;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset_n = ($urandom_range(0, 99) < rst_pct) ? 1'b0 : 1'b1;
            a_valid = ($urandom_range(0, 99) < a_pct);
            a_reg   = pick_reg();
            a_data  = {$urandom, $urandom};
            b_valid = ($urandom_range(0, 99) < b_pct);
            b_reg   = pick_reg();
            b_data  = {$urandom, $urandom};
            #1;
            starving    = (q_reg.size() > 0) && (losses >= MAX_WAIT);
            exp_a_ready = reset_n && !starving;
            exp_b_ready = reset_n && (q_reg.size() == 0);
            exp_pending = '0;
            if (q_reg.size() > 0 && q_reg[0] != ZERO_REG) exp_pending[q_reg[0]] = 1'b1;

            check_value("a_ready",       64'(a_ready),       64'(exp_a_ready));
            check_value("b_ready",       64'(b_ready),       64'(exp_b_ready));
            check_value("pending",       64'(pending),       64'(exp_pending));
            check_value("regWrite",      64'(regWrite),      64'(m_we));
            check_value("writeRegister", 64'(writeRegister), 64'(m_reg));
            check_value("writeData",     64'(writeData),     64'(m_data));
            check_value("b_forced",      64'(b_forced),      64'(m_forced));

            // Predict what the coming edge does
            if (!reset_n) begin
                model_reset();
            end else begin
                m_forced = 1'b0;
                if (q_reg.size() > 0 && (starving || !a_valid)) begin
                    m_reg    = 5'(q_reg[0]);
                    m_data   = q_data[0];
                    m_we     = (q_reg[0] != ZERO_REG);
                    m_forced = starving;
                    void'(q_reg.pop_front());
                    void'(q_data.pop_front());
                    losses = 0;
                end else if (a_valid) begin
                    m_reg  = a_reg;
                    m_data = a_data;
                    m_we   = (a_reg != 5'(ZERO_REG));
                    if (q_reg.size() > 0) losses++;
                end else begin
                    m_we = 1'b0;
                end
                if (b_valid && exp_b_ready) begin
                    q_reg.push_back(int'(b_reg));
                    q_data.push_back(b_data);
                    losses = 0;
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_reg   = 5'd3;
        b_reg   = 5'd4;
        a_data  = '0;
        b_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);

        // Held in reset with both sources requesting
        run_cycles(4, 100, 100, 100);
        // Heavy A traffic: drives the starvation override
        run_cycles(1500, 95, 60, 0);
        // Mixed traffic with occasional mid-operation resets
        run_cycles(1500, 50, 50, 3);
        // Light traffic: B mostly drains immediately
        run_cycles(800, 20, 40, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
